// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: handshake and status bundle for the pipeline controller.
//   in_valid/in_ready    : upstream offer / accept
//   out_valid/out_ready  : last-stage item / downstream take
//   flush                : discard all in-flight items
//   stage_en             : per-stage datapath load enables (bit 0 = input stage)
//   stage_valid          : per-stage valid bits
//   occupancy            : number of valid stages
//   stall_cnt            : saturating count of output stall cycles
// master = environment side (drives in_valid/out_ready/flush), slave = controller.
interface pipe_ctrl_if #(
  parameter int STAGES = 3,
  parameter int CW     = $clog2(STAGES + 1)
);
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic              flush;
  logic [STAGES-1:0] stage_en;
  logic [STAGES-1:0] stage_valid;
  logic [CW-1:0]     occupancy;
  logic [15:0]       stall_cnt;

  modport master (
    output in_valid, out_ready, flush,
    input  in_ready, out_valid, stage_en, stage_valid, occupancy, stall_cnt
  );

  modport slave (
    input  in_valid, out_ready, flush,
    output in_ready, out_valid, stage_en, stage_valid, occupancy, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: valid/enable controller for a STAGES-deep pipeline with bubble
// collapsing, flush, occupancy tracking and a saturating output-stall counter.
// Ports:
//   clock : single clock, all state on posedge
//   reset : synchronous active-high reset (overrides flush and handshakes)
//   bus   : pipe_ctrl_if slave modport (handshakes, flush, enables, status)
module pipe_ctrl #(
  parameter int STAGES = 3,
  parameter int CW     = $clog2(STAGES + 1)
) (
  input  logic       clock,
  input  logic       reset,
  pipe_ctrl_if.slave bus
);

  logic [STAGES-1:0] v_q, v_d;
  logic [CW-1:0]     occ_q, occ_d;
  logic [15:0]       stall_q, stall_d;

  logic              block;
  logic [STAGES-1:0] bub;
  logic [STAGES-1:0] sfx;
  logic [STAGES-1:0] en;
  logic [STAGES-1:0] shifted;

  // Enable chain en[k] = !v[k] | en[k+1] unrolled: a stage loads when
  // downstream is taking, or when any stage at or after it holds a bubble.
  always_comb begin
    block = reset | bus.flush;
    bub   = ~v_q;
    sfx   = bub;
    for (int unsigned i = 1; i < STAGES; i++) begin
      sfx = sfx | (bub >> i);
    end
    en = '0;
    if (!block) begin
      en = sfx | {STAGES{bus.out_ready}};
    end
  end

  always_comb begin
    shifted = {v_q[STAGES-2:0], bus.in_valid};
    v_d     = (en & shifted) | (~en & v_q);
    if (block) begin
      v_d = '0;
    end
    occ_d = CW'($countones(v_d));
  end

  always_comb begin
    bus.in_ready    = en[0];
    bus.out_valid   = !block && v_q[STAGES-1];
    bus.stage_en    = en;
    bus.stage_valid = v_q;
    bus.occupancy   = occ_q;
    bus.stall_cnt   = stall_q;
  end

  always_comb begin
    stall_d = stall_q;
    if (bus.out_valid && !bus.out_ready && (stall_q != '1)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v_q     <= '0;
      occ_q   <= '0;
      stall_q <= '0;
    end else begin
      v_q     <= v_d;
      occ_q   <= occ_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
  localparam int S  = 3;
  localparam int CW = $clog2(S + 1);

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pipe_ctrl_if #(.STAGES(S), .CW(CW)) bus ();

  pipe_ctrl #(.STAGES(S), .CW(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Bench-side datapath: tag registers loaded by the controller's enables.
  logic [15:0] in_tag;
  logic [15:0] dp [S];
  always @(posedge clock) begin
    if (bus.stage_en[0]) dp[0] <= in_tag;
    for (int k = 1; k < S; k++) begin
      if (bus.stage_en[k]) dp[k] <= dp[k-1];
    end
  end

  // Reference model state: item presence per stage, stall counter, and
  // scoreboard of accepted tags in emission order.
  bit           mv [S];
  int           m_stall;
  bit           e_rdy, e_ov;
  bit [S-1:0]   e_en;
  logic [15:0]  sb_q [$];
  bit           chk_en = 1'b0;
  int           n_checks = 0;
  int           n_fail = 0;
  int           next_tag = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [S-1:0] pack_mv();
    bit [S-1:0] r;
    for (int k = 0; k < S; k++) r[k] = mv[k];
    return r;
  endfunction

  // One clock cycle of stimulus, called just after a posedge.
  task automatic step(input bit iv, input bit ordy, input bit fl, input bit rst);
    bit nv [S];
    int top;
    int ns;
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    bus.flush     = fl;
    reset         = rst;
    in_tag        = 16'hdead;
    if (iv) begin
      in_tag   = next_tag[15:0];
      next_tag = next_tag + 1;
    end

    // Expected combinational behaviour: with downstream taking, everything
    // moves; otherwise every stage up to the highest empty one moves.
    e_en = '0;
    e_ov = 1'b0;
    if (!rst && !fl) begin
      e_ov = mv[S-1];
      if (ordy) begin
        e_en = '1;
      end else begin
        top = -1;
        for (int k = 0; k < S; k++) if (!mv[k]) top = k;
        for (int k = 0; k < S; k++) if (k <= top) e_en[k] = 1'b1;
      end
    end
    e_rdy = e_en[0];
    if (iv && e_rdy) sb_q.push_back(in_tag);

    for (int k = 0; k < S; k++) begin
      if (rst || fl)     nv[k] = 1'b0;
      else if (e_en[k])  nv[k] = (k == 0) ? iv : mv[k-1];
      else               nv[k] = mv[k];
    end
    ns = m_stall;
    if (rst) ns = 0;
    else if (e_ov && !ordy && m_stall < 65535) ns = m_stall + 1;

    @(posedge clock);
    #1;
    for (int k = 0; k < S; k++) mv[k] = nv[k];
    m_stall = ns;
    if (rst || fl) sb_q.delete();
  endtask

  // Monitor: compares DUT outputs with the model each cycle and pops the
  // scoreboard whenever the DUT hands an item downstream.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("in_ready",    32'(bus.in_ready),    32'(e_rdy));
      chk("out_valid",   32'(bus.out_valid),   32'(e_ov));
      chk("stage_en",    32'(bus.stage_en),    32'(e_en));
      chk("stage_valid", 32'(bus.stage_valid), 32'(pack_mv()));
      chk("occupancy",   32'(bus.occupancy),   32'($countones(pack_mv())));
      chk("stall_cnt",   32'(bus.stall_cnt),   32'(m_stall));
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL emit_unexpected: got tag %0h expected no item", dp[S-1]);
        end else begin
          chk("emit_tag", 32'(dp[S-1]), 32'(sb_q.pop_front()));
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < S; k++) mv[k] = 1'b0;
    m_stall = 0;
    step(0, 0, 0, 1);
    chk_en = 1'b1;
    step(1, 1, 1, 1);

    // Single item into an empty pipe.
    step(1, 1, 0, 0);
    repeat (5) step(0, 1, 0, 0);

    // Continuous streaming.
    repeat (10) step(1, 1, 0, 0);
    repeat (4) step(0, 1, 0, 0);

    // Fill, stall, drain.
    repeat (3) step(1, 0, 0, 0);
    repeat (5) step(1, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0);

    // Bubble squeeze: lone item in stage 0, downstream stalled.
    step(1, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    repeat (4) step(0, 1, 0, 0);

    // Flush of a full pipe with both handshakes asserted.
    repeat (3) step(1, 0, 0, 0);
    step(1, 1, 1, 0);
    repeat (2) step(0, 1, 0, 0);

    // Randomised traffic with occasional flush and reset.
    for (int n = 0; n < 2000; n++) begin
      step(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 60),
           1'($urandom_range(0, 99) < 2),  1'($urandom_range(0, 99) < 1));
    end

    // Reset mid-stream on a full, stalled pipe.
    repeat (4) step(1, 0, 0, 0);
    step(1, 1, 0, 1);
    repeat (2) step(0, 1, 0, 0);

    // Long stall to drive the counter into saturation.
    repeat (3) step(1, 0, 0, 0);
    for (int n = 0; n < 65540; n++) step(1'($urandom_range(0, 1)), 0, 0, 0);
    repeat (5) step(0, 1, 0, 0);

    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
